// File: rtl/stage_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package stage_fetch_pkg;

  localparam int unsigned INSTR_SIZE       = 32;
  localparam int unsigned INSTR_ALIGN_BITS = 2;

  localparam logic [INSTR_SIZE-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [INSTR_SIZE-1:0] PC_INCR   = 32'd4;

  typedef enum logic {
    RUN,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_SIZE-1:0] pc;
    logic [INSTR_SIZE-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/stage_fetch_if.sv
// Instruction-memory request/grant plus in-order response channel.
interface stage_fetch_if;
  import stage_fetch_pkg::*;

  logic                  imem_req;
  logic [INSTR_SIZE-1:0] imem_addr;
  logic                  imem_gnt;
  logic                  imem_rvalid;
  logic [INSTR_SIZE-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/stage_fetch_fifo.sv
// Small synchronous FIFO of fetch entries; used both as the output buffer
// and as the in-flight address tag queue.
module stage_fetch_fifo
  import stage_fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     din,
  output fetch_entry_t     dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy tracking; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Entry storage; contents are don't-care while the slot is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/stage_fetch.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests with
// credit-based flow control, buffers responses for decode and squashes stale
// responses after a redirect.
// Optional: define STAGE_FETCH_PERF_CNT_EN to add stall/flush perf counters.
module stage_fetch
  import stage_fetch_pkg::*;
#(
  parameter logic [INSTR_SIZE-1:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned           FIFO_DEPTH      = 2,
  parameter int unsigned           MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  stage_fetch_if.master         imem_if,
  input  logic                  redirect,
  input  logic [INSTR_SIZE-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [INSTR_SIZE-1:0] instr,
  output logic [INSTR_SIZE-1:0] pc_o
`ifdef STAGE_FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall_cycles,
  output logic [31:0]           perf_flush_count
`endif
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_t          state_q, state_d;
  logic [INSTR_SIZE-1:0] pc_q, pc_last_q;
  logic [OUT_W-1:0]      outstanding, drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]      fifo_count;
  logic                  req_c, fire, rsp, credits_ok;
  fetch_entry_t          tag_din, tag_head, out_din, out_head;
  logic                  tag_full, tag_empty, out_full, out_empty;
  logic                  out_push, out_pop;
  logic                  unused_bits;

  assign credits_ok = (32'(outstanding) + 32'(fifo_count) < FIFO_DEPTH) &&
                      (32'(outstanding) < MAX_OUTSTANDING);
  assign fire       = req_c && imem_if.imem_gnt;
  assign rsp        = imem_if.imem_rvalid && (outstanding != '0);

  assign imem_if.imem_req  = req_c;
  assign imem_if.imem_addr = pc_q;

  // Issued addresses in flight; occupancy doubles as the outstanding count.
  assign tag_din.pc    = pc_q;
  assign tag_din.instr = '0;

  stage_fetch_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_q (
    .clk   (clk),
    .reset (reset),
    .push  (fire),
    .pop   (rsp),
    .flush (1'b0),
    .din   (tag_din),
    .dout  (tag_head),
    .count (outstanding),
    .full  (tag_full),
    .empty (tag_empty)
  );

  // Output buffer toward decode; responses owed to a squashed stream never enter.
  assign out_din.pc    = tag_head.pc;
  assign out_din.instr = imem_if.imem_rdata;
  assign out_push      = rsp && (drop_cnt_q == '0) && !redirect;
  assign out_pop       = instr_valid && instr_ready;

  stage_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_out_q (
    .clk   (clk),
    .reset (reset),
    .push  (out_push),
    .pop   (out_pop),
    .flush (redirect),
    .din   (out_din),
    .dout  (out_head),
    .count (fifo_count),
    .full  (out_full),
    .empty (out_empty)
  );

  assign instr_valid = !out_empty;
  assign instr       = out_empty ? NOP_INSTR : out_head.instr;
  assign pc_o        = out_empty ? pc_last_q : out_head.pc;

  assign unused_bits = ^{tag_head.instr, tag_full, tag_empty, out_full,
                         redirect_pc[INSTR_ALIGN_BITS-1:0]};

  // Next state, drop accounting and request generation.
  always_comb begin
    state_d    = state_q;
    drop_cnt_d = drop_cnt_q;
    req_c      = 1'b0;
    if (redirect) begin
      drop_cnt_d = outstanding - OUT_W'(rsp);
      state_d    = (drop_cnt_d != '0) ? DRAIN : RUN;
    end else begin
      if (rsp && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - OUT_W'(1);
      case (state_q)
        RUN:     req_c = !reset && credits_ok;
        DRAIN:   if (drop_cnt_d == '0) state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // State, PC and drop-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      drop_cnt_q <= '0;
      pc_last_q  <= RESET_PC;
    end else begin
      state_q    <= state_d;
      drop_cnt_q <= drop_cnt_d;
      if (redirect) begin
        pc_q <= {redirect_pc[INSTR_SIZE-1:INSTR_ALIGN_BITS], {INSTR_ALIGN_BITS{1'b0}}};
      end else if (fire) begin
        pc_q <= pc_q + PC_INCR;
      end
      if (!out_empty) pc_last_q <= out_head.pc;
    end
  end

`ifdef STAGE_FETCH_PERF_CNT_EN
  // Saturating decode-stall and redirect counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_flush_count  <= '0;
    end else begin
      if (instr_valid && !instr_ready && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (redirect && (perf_flush_count != '1))
        perf_flush_count <= perf_flush_count + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  // A response with nothing in flight is a memory-side protocol error.
  rvalid_needs_outstanding: assert property (
    @(posedge clk) disable iff (reset) imem_if.imem_rvalid |-> (outstanding != '0));
`endif

endmodule

// File: tb/tb_stage_fetch.sv
// Directed bench for stage_fetch with an in-order memory model and a
// PC-sequence scoreboard on both the issue and delivery sides.
module tb_stage_fetch;
  import stage_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc_o;
`ifdef STAGE_FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flush_count;
`endif

  stage_fetch_if m_if ();

  stage_fetch #(
    .RESET_PC        (32'h0000_0000),
    .FIFO_DEPTH      (2),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .imem_if           (m_if),
    .redirect          (redirect),
    .redirect_pc       (redirect_pc),
    .instr_valid       (instr_valid),
    .instr_ready       (instr_ready),
    .instr             (instr),
    .pc_o              (pc_o)
`ifdef STAGE_FETCH_PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] first_addr;
    logic [31:0] second_addr;
  } redir_vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc, exp_addr;
  logic [31:0] mem_q[$];
  bit          mem_hold;
  int          issued, accepted, stall_model, flush_model;
  bit          last_fire, last_acc, last_valid, acc_seen;
  logic [31:0] last_addr, first_acc_pc;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0001;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // One clock: sample at negedge, score, then advance the memory model.
  task automatic tick();
    @(negedge clk);
    last_valid = instr_valid;
    last_acc   = instr_valid && instr_ready && !reset && !redirect;
    last_fire  = m_if.imem_req && m_if.imem_gnt;
    last_addr  = m_if.imem_addr;
    if (!reset) begin
      if (!instr_valid) check("nop_when_empty", instr, NOP_INSTR);
      if (redirect) check("no_req_on_redirect", 32'(m_if.imem_req), 32'd0);
      if (last_acc) begin
        check("deliver_pc", pc_o, exp_pc);
        check("deliver_instr", instr, instr_of(exp_pc));
        if (!acc_seen) begin
          acc_seen     = 1'b1;
          first_acc_pc = pc_o;
        end
        exp_pc += 32'd4;
        accepted++;
      end
      if (last_fire) begin
        check("issue_addr", last_addr, exp_addr);
        exp_addr += 32'd4;
        issued++;
      end
      if (instr_valid && !instr_ready) stall_model++;
      if (redirect) flush_model++;
    end
    @(posedge clk);
    #1;
    if (reset) begin
      mem_q.delete();
      m_if.imem_rvalid = 1'b0;
      m_if.imem_rdata  = '0;
    end else begin
      if (m_if.imem_rvalid) void'(mem_q.pop_front());
      if (last_fire) mem_q.push_back(last_addr);
      if (!mem_hold && mem_q.size() > 0) begin
        m_if.imem_rvalid = 1'b1;
        m_if.imem_rdata  = instr_of(mem_q[0]);
      end else begin
        m_if.imem_rvalid = 1'b0;
        m_if.imem_rdata  = '0;
      end
    end
  endtask

  task automatic apply_reset();
    reset    = 1'b1;
    redirect = 1'b0;
    mem_hold = 1'b0;
    repeat (3) tick();
    check("rst_req", 32'(m_if.imem_req), 32'd0);
    check("rst_addr", m_if.imem_addr, 32'h0000_0000);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, NOP_INSTR);
    check("rst_pc_o", pc_o, 32'h0000_0000);
    reset       = 1'b0;
    exp_pc      = 32'h0000_0000;
    exp_addr    = 32'h0000_0000;
    issued      = 0;
    accepted    = 0;
    stall_model = 0;
    flush_model = 0;
    acc_seen    = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    tick();
    redirect = 1'b0;
    exp_pc   = {target[31:2], 2'b00};
    exp_addr = {target[31:2], 2'b00};
    acc_seen = 1'b0;
  endtask

  task automatic wait_fire(input string name, output logic [31:0] addr);
    bit got = 1'b0;
    addr = '0;
    for (int i = 0; i < 30 && !got; i++) begin
      tick();
      if (last_fire) begin
        got  = 1'b1;
        addr = last_addr;
      end
    end
    if (!got) timeout(name);
  endtask

  task automatic wait_first_acc(input string name, output logic [31:0] pc);
    for (int i = 0; i < 30 && !acc_seen; i++) tick();
    pc = first_acc_pc;
    if (!acc_seen) timeout(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    redir_vec_t  vecs[5];
    logic [31:0] a1, a2, p1;
    int          first;

    vecs[0] = '{rpc: 32'h0000_0203, first_addr: 32'h0000_0200, second_addr: 32'h0000_0204};
    vecs[1] = '{rpc: 32'h0000_0100, first_addr: 32'h0000_0100, second_addr: 32'h0000_0104};
    vecs[2] = '{rpc: 32'h0000_0007, first_addr: 32'h0000_0004, second_addr: 32'h0000_0008};
    vecs[3] = '{rpc: 32'h0000_1001, first_addr: 32'h0000_1000, second_addr: 32'h0000_1004};
    vecs[4] = '{rpc: 32'hFFFF_FFFE, first_addr: 32'hFFFF_FFFC, second_addr: 32'h0000_0000};

    reset            = 1'b1;
    redirect         = 1'b0;
    redirect_pc      = '0;
    instr_ready      = 1'b1;
    m_if.imem_gnt    = 1'b1;
    m_if.imem_rvalid = 1'b0;
    m_if.imem_rdata  = '0;
    mem_hold         = 1'b0;
    exp_pc           = '0;
    exp_addr         = '0;

    // Reset, then streaming fetch with first-word latency.
    apply_reset();
    first = 0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (last_valid && first == 0) first = k;
    end
    check("first_valid_cycle", 32'(first), 32'd3);

    // Decode stall: buffer fills, credits run out, nothing lost on release.
    instr_ready = 1'b0;
    repeat (10) tick();
    check("stall_req_low", 32'(m_if.imem_req), 32'd0);
    check("stall_valid", 32'(instr_valid), 32'd1);
    check("stall_buffered", 32'(issued - accepted), 32'd2);
    check("stall_in_flight", 32'(mem_q.size()), 32'd0);
    instr_ready = 1'b1;
    repeat (12) tick();

    // Two in flight (8, 12); redirect lands with the response for 8.
    apply_reset();
    for (int i = 0; i < 20 && issued < 2; i++) tick();
    m_if.imem_gnt = 1'b0;
    for (int i = 0; i < 20 && accepted < 2; i++) tick();
    check("t3_delivered_two", 32'(accepted), 32'd2);
    mem_hold      = 1'b1;
    m_if.imem_gnt = 1'b1;
    for (int i = 0; i < 20 && mem_q.size() < 2; i++) tick();
    check("t3_issued_four", 32'(issued), 32'd4);
    mem_hold = 1'b0;
    tick();
    check("t3_rvalid_before_redirect", 32'(m_if.imem_rvalid), 32'd1);
    do_redirect(32'h0000_0100);
    check("t3_flush_valid", 32'(instr_valid), 32'd0);
    check("t3_drain_no_req", 32'(m_if.imem_req), 32'd0);
    tick();
    check("t3_still_empty", 32'(instr_valid), 32'd0);
    wait_fire("t3_fire", a1);
    check("t3_next_addr", a1, 32'h0000_0100);
    wait_first_acc("t3_acc", p1);
    check("t3_first_pc", p1, 32'h0000_0100);

    // Redirect alignment and PC wrap table.
    foreach (vecs[i]) begin
      do_redirect(vecs[i].rpc);
      wait_fire("vec_fire1", a1);
      check("vec_first_addr", a1, vecs[i].first_addr);
      wait_fire("vec_fire2", a2);
      check("vec_second_addr", a2, vecs[i].second_addr);
      wait_first_acc("vec_acc", p1);
      check("vec_first_pc", p1, vecs[i].first_addr);
    end

    // Redirect again while draining: drop count recomputed, no stale words.
    mem_hold = 1'b1;
    for (int i = 0; i < 20 && mem_q.size() < 2; i++) tick();
    check("t5_two_in_flight", 32'(mem_q.size()), 32'd2);
    do_redirect(32'h0000_0400);
    check("t5_flush_valid", 32'(instr_valid), 32'd0);
    check("t5_drain_no_req", 32'(m_if.imem_req), 32'd0);
    tick();
    do_redirect(32'h0000_0500);
    check("t5_drain2_no_req", 32'(m_if.imem_req), 32'd0);
    mem_hold = 1'b0;
    wait_fire("t5_fire", a1);
    check("t5_next_addr", a1, 32'h0000_0500);
    wait_first_acc("t5_acc", p1);
    check("t5_first_pc", p1, 32'h0000_0500);
    repeat (6) tick();

`ifdef STAGE_FETCH_PERF_CNT_EN
    check("perf_stall_model", perf_stall_cycles, 32'(stall_model));
    check("perf_flush_model", perf_flush_count, 32'(flush_model));
    apply_reset();
    check("perf_rst_stall", perf_stall_cycles, 32'd0);
    instr_ready = 1'b0;
    for (int i = 0; i < 20 && !last_valid; i++) tick();
    repeat (4) tick();
    instr_ready = 1'b1;
    tick();
    do_redirect(32'h0000_0040);
    tick();
    do_redirect(32'h0000_0080);
    tick();
    check("perf_stall_5", perf_stall_cycles, 32'd5);
    check("perf_flush_2", perf_flush_count, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_fetch.md
Name: stage_fetch

Overview:
- Instruction-fetch stage directly upstream of the decode stage. Owns the PC register.
- Issues in-order requests to instruction memory over a req/gnt + rvalid interface, with up to MAX_OUTSTANDING requests in flight.
- Buffers returned words with their PCs and presents {pc, instr} to decode through a valid/ready handshake.
- Handles redirects from execute (taken branch/jump) by flushing the buffer and dropping stale responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset (bits [1:0] must be 0).
- FIFO_DEPTH, 2, entries in the output buffer; power of two, ≥2.
- MAX_OUTSTANDING, 2, maximum imem requests granted but not yet answered; ≥1.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  INSTR_SIZE  byte address of the request (= pc_q).
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid; responses return in request order, ≥1 cycle after gnt.
- imem_rdata  in  INSTR_SIZE  instruction word.
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  INSTR_SIZE  new fetch address.
- instr_valid  out  1  instr/pc_o valid toward decode.
- instr_ready  in  1  decode accepts (low = decode stall).
- instr  out  INSTR_SIZE  instruction to decode.
- pc_o  out  INSTR_SIZE  PC of instr.

Behaviour:
- State machine: RUN, DRAIN. Reset enters RUN with:
  - pc_q = RESET_PC
  - outstanding = 0, drop_cnt = 0, FIFO empty
  - imem_req = 0, instr_valid = 0, instr = NOP (32'h0000_0013), pc_o = RESET_PC
- Credit rule: imem_req = (state==RUN) && !redirect && (outstanding + fifo_count < FIFO_DEPTH) && (outstanding < MAX_OUTSTANDING). A response therefore always finds space.
- imem_req is a combinational function of registered state only; it never depends on imem_gnt.
- On imem_req && imem_gnt:
  - pc_q += 4, wrapping mod 2^INSTR_SIZE.
  - The issued address is pushed onto a tag queue of depth MAX_OUTSTANDING.
  - outstanding += 1.
- On imem_rvalid:
  - Pop the tag queue; outstanding -= 1.
  - If drop_cnt == 0, push {tag, imem_rdata} into the FIFO; otherwise discard and drop_cnt -= 1.
- Simultaneous gnt and rvalid: outstanding is unchanged; tag queue push and pop both occur.
- imem_rvalid with outstanding == 0 is a protocol error; it is ignored, plus an assertion under simulation.
- Output: FIFO head drives instr/pc_o when instr_valid = 1. The entry pops on instr_valid && instr_ready. When empty, instr = NOP and pc_o holds its last value.
- Latency: rvalid at cycle N → instr_valid at N+1 (registered FIFO; no bypass).
- FIFO full plus a push is impossible by the credit rule. Simultaneous push and pop while full is legal.
- Redirect (highest priority, any state):
  - pc_q ← {redirect_pc[INSTR_SIZE-1:2], 2'b00}.
  - FIFO flushed; instr_valid = 0 the next cycle.
  - drop_cnt ← outstanding − (imem_rvalid ? 1 : 0). The response arriving in the redirect cycle is itself discarded.
  - No request in the redirect cycle. Next state is DRAIN if the new drop_cnt > 0, else RUN.
- DRAIN: no requests. Transition to RUN in the cycle after drop_cnt reaches 0. A redirect in DRAIN reloads pc_q and recomputes drop_cnt by the same rule.
- Reset mid-operation: all state returns to reset values. External memory is assumed to be reset by the same signal, so in-flight responses are lost.

Optional Feature:
- Macro STAGE_FETCH_PERF_CNT_EN.
- When defined, adds output ports:
  - perf_stall_cycles (32): increments each cycle instr_valid && !instr_ready.
  - perf_flush_count (32): increments per redirect.
  - Both saturate at all-ones and reset to 0.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Decomposition:
- PARAMS_pkg gains:
  - NOP_INSTR = 32'h0000_0013
  - INSTR_ALIGN_BITS = 2
  - PC_INCR = 4
  - typedef fetch_state_t {RUN, DRAIN}
  - typedef fetch_entry_t {pc, instr}
- One sub-module, fetch_fifo: parameterised sync FIFO of fetch_entry_t with push, pop, flush, count, full, empty. Reused for the tag queue (instr field unused).

Test Plan:
- Reset, RESET_PC=0, gnt tied 1, rvalid 1 cycle after gnt, ready=1 → addresses 0,4,8,…; instr_valid first rises 3 cycles after reset release with pc_o=0.
- ready held 0 for 10 cycles → at most FIFO_DEPTH (2) entries buffered, imem_req=0 once credits are exhausted, no word lost; on release the PCs continue contiguously.
- Two requests outstanding (addr 8,12), redirect to 0x100 in the same cycle as rvalid for 8 → both responses dropped; FIFO empty; next request addr 0x100; first delivered pc_o=0x100.
- redirect_pc=0x203 → imem_addr=0x200.
- Redirect repeated during DRAIN → drop_cnt recomputed; no stale word reaches decode.
- pc_q=0xFFFF_FFFC, gnt → next request addr 0x0000_0000. With STAGE_FETCH_PERF_CNT_EN: 5 stall cycles and 2 redirects → perf_stall_cycles=5, perf_flush_count=2.
